// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite (OAM) DMA controller and CPU bus arbiter.
// While idle, CPU accesses pass straight through to the memory bus. A CPU write
// to DMA_TRIG_ADDR stalls the CPU and takes the bus. The block then copies the
// 256-byte page named by the written byte to OAM_DATA_ADDR as read/write pairs,
// and finally returns the bus to the CPU.
// Optional feature macro: OAM_DMA_ALIGN_EN. When it is defined, a one-cycle
// ALIGN state is inserted after HALT whenever needed, so that every READ lands
// on an even cycle and every WRITE on an odd cycle. When it is undefined, HALT
// always goes straight to READ.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_wen,
   input  logic        cpu_ren,
   output logic        cpu_rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_wen,
   output logic        bus_ren,
   input  logic [7:0]  bus_rdata,
   output logic        dma_active
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  page, page_nxt;   // source page latched from the trigger write
   logic [7:0]  idx, idx_nxt;     // byte offset within the page
   logic        trig;

`ifdef OAM_DMA_ALIGN_EN
   logic        par;              // cycle parity since reset release (0 = even)

   // Free-running parity bit; cleared by reset so the first released cycle is even
   always_ff @(posedge clk) begin
      if (rst) begin
         par <= 1'b0;
      end else begin
         par <= ~par;
      end
   end
`endif

   assign trig = cpu_wen && (cpu_addr == DMA_TRIG_ADDR);

   // State and copy-progress registers; reset abandons any copy in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         page  <= 8'h00;
         idx   <= 8'h00;
      end else begin
         state <= state_nxt;
         page  <= page_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state logic and combinational bus/CPU handshake outputs
   always_comb begin
      state_nxt  = state;
      page_nxt   = page;
      idx_nxt    = idx;
      cpu_rdy    = 1'b0;
      dma_active = 1'b1;
      bus_addr   = 16'h0000;
      bus_wdata  = 8'h00;
      bus_wen    = 1'b0;
      bus_ren    = 1'b0;

      case (state)
         IDLE: begin
            // CPU owns the bus; the trigger write itself also reaches the bus
            cpu_rdy    = 1'b1;
            dma_active = 1'b0;
            bus_addr   = cpu_addr;
            bus_wdata  = cpu_wdata;
            bus_wen    = cpu_wen;
            bus_ren    = cpu_ren;
            if (trig) begin
               page_nxt  = cpu_wdata;
               state_nxt = HALT;
            end
         end

         HALT: begin
`ifdef OAM_DMA_ALIGN_EN
            // The cycle after HALT has parity ~par; READ must start on even
            state_nxt = par ? READ : ALIGN;
`else
            state_nxt = READ;
`endif
         end

         ALIGN: begin
            state_nxt = READ;
         end

         READ: begin
            bus_addr  = {page, idx};
            bus_ren   = 1'b1;
            state_nxt = WRITE;
         end

         WRITE: begin
            // Read data arrives this cycle and is forwarded without a holding register
            bus_addr  = OAM_DATA_ADDR;
            bus_wdata = bus_rdata;
            bus_wen   = 1'b1;
            idx_nxt   = idx + 8'd1;
            state_nxt = (idx == 8'hFF) ? IDLE : READ;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
